// File: rtl/sort_pkg.sv
// Shared defaults and state encoding for the serial insertion sorter.
package sort_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = 8;
  localparam int CNT_W = $clog2(N_DEF + 1);

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/sort_cell.sv
// One slot of the insertion array: keeps, takes the new value, or takes the
// left neighbour's value depending on where the new element belongs.
module sort_cell #(
  parameter int W = 8
) (
  input  logic [W-1:0] own_val,
  input  logic [W-1:0] left_val,
  input  logic [W-1:0] d,
  input  logic         occupied,
  input  logic         left_gt,
  output logic [W-1:0] next_val,
  output logic         gt
);

  // Strict compare keeps ties stable: an equal newcomer lands after the old equals.
  assign gt = !occupied || (own_val > d);

  always_comb begin
    if (left_gt) begin
      next_val = left_val;
    end else if (gt) begin
      next_val = d;
    end else begin
      next_val = own_val;
    end
  end

endmodule

// File: rtl/seq_sort8.sv
// Serial-in/serial-out insertion sorter: loads N elements into a sorted array,
// then streams them out smallest first.
module seq_sort8
  import sort_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [N-1:0][W-1:0]   data_q, data_d;
  logic [N-1:0][W-1:0]   ins_val;
  logic [N-1:0]          gt_vec;

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic [W-1:0] left_val;
    logic         left_gt;

    if (i == 0) begin : g_first
      assign left_val = '0;
      assign left_gt  = 1'b0;
    end else begin : g_rest
      assign left_val = data_q[i-1];
      assign left_gt  = gt_vec[i-1];
    end

    sort_cell #(.W(W)) u_cell (
      .own_val  (data_q[i]),
      .left_val (left_val),
      .d        (in_data),
      .occupied (count_q > CW'(i)),
      .left_gt  (left_gt),
      .next_val (ins_val[i]),
      .gt       (gt_vec[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  // Emptied slots refill with zero so a drained array reads like a reset one.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          data_d  = ins_val;
          count_d = count_q + CW'(1);
          if (count_q == CW'(N - 1)) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          for (int i = 0; i < N - 1; i++) begin
            data_d[i] = data_q[i+1];
          end
          data_d[N-1] = '0;
          count_d     = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == EMIT);
  assign out_data  = data_q[0];
  assign out_last  = (state_q == EMIT) && (count_q == CW'(1));
  assign busy      = (count_q != '0) || (state_q == EMIT);

endmodule

// File: tb/tb_seq_sort8.sv
// Self-checking bench for seq_sort8: queue-based reference model compared every
// cycle, plus literal frame expectations for the directed cases.
module tb_seq_sort8;

  typedef logic [7:0] frame_t [8];

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  bit         m_emit;
  logic [7:0] m_in[$];
  logic [7:0] m_out[$];
  logic [7:0] got[$];

  seq_sort8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Reference model: collect a frame, sort it as a whole, pop one per handshake.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_emit = 1'b0;
      m_in.delete();
      m_out.delete();
    end else if (!m_emit) begin
      if (in_valid) begin
        m_in.push_back(in_data);
        if (m_in.size() == 8) begin
          m_out = m_in;
          m_out.sort();
          m_in.delete();
          m_emit = 1'b1;
        end
      end
    end else if (out_ready) begin
      void'(m_out.pop_front());
      if (m_out.size() == 0) m_emit = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (check_en && !rst) begin
      chk("in_ready", int'(in_ready), int'(!m_emit));
      chk("out_valid", int'(out_valid), int'(m_emit));
      chk("out_last", int'(out_last), int'(m_emit && m_out.size() == 1));
      chk("busy", int'(busy), int'(m_emit || m_in.size() != 0));
      if (m_emit) chk("out_data", int'(out_data), int'(m_out[0]));
      if (out_valid && out_ready) got.push_back(out_data);
    end
  end

  task automatic apply_stimulus(input frame_t vals, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      int waited = 0;
      in_valid = 1'b1;
      in_data  = vals[k];
      while (!in_ready && waited < 100) begin
        @(posedge clk); #1;
        waited++;
      end
      if (waited >= 100) timeout_fail("in_handshake");
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_ready, input bit tease, input logic [7:0] tease_val,
                       input int stop_after);
    int cyc = 0;
    got.delete();
    while (got.size() < stop_after && cyc < 300) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tease) begin
        in_valid = 1'b1;
        in_data  = tease_val;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (cyc >= 300) timeout_fail("drain");
  endtask

  task automatic check_output(input string name, input frame_t exp);
    chk({name, "_count"}, got.size(), 8);
    for (int k = 0; k < 8; k++) begin
      int a;
      a = (k < got.size()) ? int'(got[k]) : -1;
      chk($sformatf("%s[%0d]", name, k), a, int'(exp[k]));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_in_ready"}, int'(in_ready), 1);
    chk({name, "_out_valid"}, int'(out_valid), 0);
    chk({name, "_out_last"}, int'(out_last), 0);
    chk({name, "_out_data"}, int'(out_data), 0);
    chk({name, "_busy"}, int'(busy), 0);
  endtask

  task automatic mid_reset(input string name);
    @(posedge clk); #3;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check_reset_outputs(name);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    frame_t f;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst      = 1'b0;
    check_en = 1'b1;

    $display("[TB] reverse frame, back-to-back");
    apply_stimulus('{8, 7, 6, 5, 4, 3, 2, 1}, 8, 0);
    chk("latency_valid", int'(out_valid), 1);
    drain(1'b0, 1'b0, 8'd0, 8);
    check_output("reverse", '{1, 2, 3, 4, 5, 6, 7, 8});

    $display("[TB] mixed frames with input offered during drain");
    apply_stimulus('{18, 72, 36, 58, 44, 73, 27, 31}, 8, 0);
    drain(1'b0, 1'b1, 8'd80, 8);
    check_output("mixed1", '{18, 27, 31, 36, 44, 58, 72, 73});
    apply_stimulus('{80, 86, 56, 1, 52, 12, 20, 17}, 8, 0);
    drain(1'b0, 1'b0, 8'd0, 8);
    check_output("mixed2", '{1, 12, 17, 20, 52, 56, 80, 86});

    $display("[TB] duplicates and extremes");
    apply_stimulus('{8, 17, 69, 42, 90, 0, 89, 42}, 8, 0);
    drain(1'b0, 1'b0, 8'd0, 8);
    check_output("dups", '{0, 8, 17, 42, 42, 69, 89, 90});
    apply_stimulus('{255, 255, 255, 255, 255, 255, 255, 255}, 8, 0);
    drain(1'b0, 1'b0, 8'd0, 8);
    check_output("all_ff", '{255, 255, 255, 255, 255, 255, 255, 255});
    apply_stimulus('{255, 0, 255, 0, 255, 0, 255, 0}, 8, 0);
    drain(1'b0, 1'b0, 8'd0, 8);
    check_output("pairs", '{0, 0, 0, 0, 255, 255, 255, 255});

    $display("[TB] backpressure");
    apply_stimulus('{40, 3, 200, 3, 99, 150, 7, 61}, 8, 0);
    drain(1'b1, 1'b0, 8'd0, 8);
    check_output("bp", '{3, 3, 7, 40, 61, 99, 150, 200});

    $display("[TB] gapped input");
    apply_stimulus('{8, 7, 6, 5, 4, 3, 2, 1}, 8, 2);
    drain(1'b0, 1'b0, 8'd0, 8);
    check_output("gapped", '{1, 2, 3, 4, 5, 6, 7, 8});

    $display("[TB] reset during load and during emit");
    apply_stimulus('{9, 10, 11, 12, 13, 0, 0, 0}, 5, 0);
    mid_reset("rst_load");
    apply_stimulus('{5, 6, 7, 8, 1, 2, 3, 4}, 8, 0);
    drain(1'b0, 1'b0, 8'd0, 8);
    check_output("after_rst_load", '{1, 2, 3, 4, 5, 6, 7, 8});
    apply_stimulus('{90, 80, 70, 60, 50, 40, 30, 20}, 8, 0);
    drain(1'b0, 1'b0, 8'd0, 3);
    mid_reset("rst_emit");
    apply_stimulus('{5, 6, 7, 8, 1, 2, 3, 4}, 8, 0);
    drain(1'b0, 1'b0, 8'd0, 8);
    check_output("after_rst_emit", '{1, 2, 3, 4, 5, 6, 7, 8});

    $display("[TB] random frames");
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        f[k] = (r % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      end
      apply_stimulus(f, 8, $urandom_range(0, 2));
      drain(1'($urandom_range(0, 1)), 1'b0, 8'd0, 8);
      chk("rand_count", got.size(), 8);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
